// File: rtl/acc64_sequencer.sv
// acc64_sequencer: accumulates a programmed number of 64-bit operands received
// over a valid/ready stream, counting adder carry-outs, and presents
// {carry count, sum} on a held result handshake.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i, len_i   begin a run of len_i operands (sampled only when idle)
//   in_valid_i/in_ready_o/in_data_i     operand stream
//   out_valid_o/out_ready_i             result handshake
//   out_sum_o        accumulator, modulo 2^64
//   out_carry_cnt_o  number of beats whose addition carried out
//   busy_o           high whenever not idle
//
// carry_select_64_bit: 64-bit carry-select adder built from 8-bit blocks,
// each precomputing its sum for carry-in 0 and 1.

module carry_select_64_bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        carry_in,
    output logic [63:0] sum,
    output logic        carry_out
);
    localparam int unsigned BlkW = 8;
    localparam int unsigned NBlk = 8;

    logic [NBlk:0] carry;
    assign carry[0] = carry_in;

    for (genvar g = 0; g < NBlk; g++) begin : g_blk
        logic [BlkW:0] s0;
        logic [BlkW:0] s1;
        // Both candidate sums are ready before the block's carry-in resolves.
        assign s0 = {1'b0, a[g*BlkW +: BlkW]} + {1'b0, b[g*BlkW +: BlkW]};
        assign s1 = s0 + (BlkW+1)'(1);
        assign sum[g*BlkW +: BlkW] = carry[g] ? s1[BlkW-1:0] : s0[BlkW-1:0];
        assign carry[g+1]          = carry[g] ? s1[BlkW]     : s0[BlkW];
    end

    assign carry_out = carry[NBlk];
endmodule

module acc64_sequencer #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COUNT_W-1:0] len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [63:0]        in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [63:0]        out_sum_o,
    output logic [COUNT_W-1:0] out_carry_cnt_o,
    output logic               busy_o
);
    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q, state_d;
    logic [63:0]        acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] rem_q, rem_d;

    logic [63:0] add_sum;
    logic        add_carry;

    carry_select_64_bit u_adder (
        .a         (acc_q),
        .b         (in_data_i),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                // in_ready is high throughout this state, so valid alone is a handshake.
                if (in_valid_i) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, add_carry};
                    rem_d = rem_q - 1'b1;
                    if (rem_q == COUNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // A coincident start is deliberately not captured here.
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    // All handshake outputs decode the state register only.
    assign in_ready_o      = (state_q == StAccum);
    assign out_valid_o     = (state_q == StDone);
    assign busy_o          = (state_q != StIdle);
    assign out_sum_o       = acc_q;
    assign out_carry_cnt_o = cnt_q;
endmodule

// File: tb/tb_acc64_sequencer.sv
module tb_acc64_sequencer;
    localparam int unsigned CW = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [63:0]   in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [63:0]   out_sum_o;
    logic [CW-1:0] out_carry_cnt_o;
    logic          busy_o;

    acc64_sequencer #(.COUNT_W(CW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .len_i           (len_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_sum_o       (out_sum_o),
        .out_carry_cnt_o (out_carry_cnt_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    logic [63:0] ops_mem [0:255];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic recover();
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // Drives one complete run from start to result handshake. Expected result is
    // the exact 72-bit sum of the operands; carry count is its upper byte.
    task automatic run_job(input int len, input bit gaps, input int hold, input string tag);
        logic [71:0] exp;
        int idx;
        int cyc;
        bit hs;
        exp = '0;
        for (int i = 0; i < len; i++) exp = exp + {8'h00, ops_mem[i]};

        start_i = 1'b1;
        len_i   = CW'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check({tag, "_busy"}, 72'(busy_o), 72'd1);
        if (len == 0) begin
            check({tag, "_zl_ready"}, 72'(in_ready_o), 72'd0);
            check({tag, "_zl_valid"}, 72'(out_valid_o), 72'd1);
        end else begin
            check({tag, "_ready_rise"}, 72'(in_ready_o), 72'd1);
            idx = 0;
            cyc = 0;
            while (idx < len && cyc < 4 * len + 64) begin
                in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data_i  = in_valid_i ? ops_mem[idx] : {$urandom, $urandom};
                start_i    = gaps && ($urandom_range(0, 7) == 0);
                len_i      = CW'($urandom_range(0, 255));
                hs         = in_valid_i && in_ready_o;
                check({tag, "_excl"}, 72'(in_ready_o & out_valid_o), 72'd0);
                @(posedge clk_i); #1;
                cyc++;
                if (hs) idx++;
            end
            in_valid_i = 1'b0;
            start_i    = 1'b0;
            if (idx < len) check({tag, "_feed_timeout"}, 72'(idx), 72'(len));
            check({tag, "_latency_valid"}, 72'(out_valid_o), 72'd1);
            check({tag, "_done_ready"}, 72'(in_ready_o), 72'd0);
        end
        check({tag, "_result"}, {out_carry_cnt_o, out_sum_o}, exp);
        for (int h = 0; h < hold; h++) begin
            out_ready_i = 1'b0;
            start_i     = gaps && ($urandom_range(0, 1) == 0);
            @(posedge clk_i); #1;
            check({tag, "_hold_valid"}, 72'(out_valid_o), 72'd1);
            check({tag, "_hold_result"}, {out_carry_cnt_o, out_sum_o}, exp);
        end
        out_ready_i = 1'b1;
        start_i     = gaps;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        check({tag, "_post_valid"}, 72'(out_valid_o), 72'd0);
        check({tag, "_post_busy"}, 72'(busy_o), 72'd0);
        check({tag, "_post_result"}, {out_carry_cnt_o, out_sum_o}, exp);
        if (busy_o) recover();
    endtask

    typedef struct {
        string       name;
        int          len;
        logic [63:0] ops [4];
        bit          gaps;
        int          hold;
        logic [63:0] exp_sum;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;

        vecs[0] = '{"basic", 2, '{64'd5000, 64'd6125, 64'd0, 64'd0}, 1'b0, 0, 64'd11125, 8'd0};
        vecs[1] = '{"wrap", 3, '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
                    1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
        vecs[2] = '{"zero_len", 0, '{64'd0, 64'd0, 64'd0, 64'd0}, 1'b0, 1, 64'd0, 8'd0};
        vecs[3] = '{"backpressure", 4, '{64'd20000, 64'd12000, 64'd80000, 64'd9000}, 1'b1, 5,
                    64'd121000, 8'd0};
        vecs[4] = '{"two_carries", 4, '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000}, 1'b1, 2, 64'd0, 8'd2};

        @(posedge clk_i); #1;
        check("reset_in_ready", 72'(in_ready_o), 72'd0);
        check("reset_out_valid", 72'(out_valid_o), 72'd0);
        check("reset_busy", 72'(busy_o), 72'd0);
        check("reset_result", {out_carry_cnt_o, out_sum_o}, 72'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("idle_busy", 72'(busy_o), 72'd0);

        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) ops_mem[i] = vecs[v].ops[i];
            run_job(vecs[v].len, vecs[v].gaps, vecs[v].hold, vecs[v].name);
            check({vecs[v].name, "_table"}, {out_carry_cnt_o, out_sum_o},
                  {vecs[v].exp_cnt, vecs[v].exp_sum});
        end

        // Reset asserted mid-run after two accepted beats.
        for (int i = 0; i < 5; i++) ops_mem[i] = 64'd1000 + 64'(i);
        start_i = 1'b1;
        len_i   = CW'(5);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = ops_mem[i];
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        check("midrun_partial_sum", 72'(out_sum_o), 72'd2001);
        #2 rst_ni = 1'b0;
        #1;
        check("midrun_rst_ready", 72'(in_ready_o), 72'd0);
        check("midrun_rst_valid", 72'(out_valid_o), 72'd0);
        check("midrun_rst_busy", 72'(busy_o), 72'd0);
        check("midrun_rst_result", {out_carry_cnt_o, out_sum_o}, 72'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        ops_mem[0] = 64'd88000;
        run_job(1, 1'b0, 1, "rst_rerun");
        check("rst_rerun_sum", 72'(out_sum_o), 72'd88000);

        // Random regression; lengths skew short to keep the run brief.
        for (int r = 0; r < 1000; r++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 16));
            for (int i = 0; i < len; i++) begin
                ops_mem[i] = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                          : {$urandom, $urandom};
            end
            run_job(len, 1'b1, int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
